cnn_layer_sequencer: RTL and testbench

Control FSM that sequences one convolution layer of the CNN accelerator datapath. For each output-channel fold it loads the weight buffer from the weight stream, then streams activations through the PE/SIMD MAC array one pixel at a time. It drives the MAC array with accumulator clear/last strobes, weight-buffer addresses and end-of-frame tlast, and sits between the AXI-lite control block (ap_start/ap_done) and the MAC array.

---
 rtl/cnn_layer_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: control FSM for one convolution layer.
// Each output-channel fold loads the weight buffer (optionally preceded by a
// bias beat when BIAS_LOAD_EN is defined), then streams NPIX pixels of WFOLD
// beats each through the MAC array. ap_done pulses once when the layer ends.
//
// Handshake rule for every stream (w_*, a_*, b_*): a beat transfers on a
// clock edge where valid && ready are both high. Ready is combinational from
// state/counters only (never from the same stream's valid). A source holds its
// beat until it transfers.
module cnn_layer_sequencer #(
  parameter int PE   = 16,
  parameter int SIMD = 8,
  parameter int IC   = 64,
  parameter int OC   = 128,
  parameter int KH   = 3,
  parameter int KW   = 3,
  parameter int OH   = 30,
  parameter int OW   = 30,
  localparam int NF    = OC / PE,
  localparam int WFOLD = KH * KW * IC / SIMD,
  localparam int NPIX  = OH * OW,
  localparam int WAW   = ($clog2(WFOLD) > 1) ? $clog2(WFOLD) : 1,
  localparam int PXW   = ($clog2(NPIX) > 1) ? $clog2(NPIX) : 1,
  localparam int FW    = $clog2(NF) + 1
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           ap_start,
  output logic           ap_idle,
  output logic           ap_done,
  input  logic           w_valid,
  output logic           w_ready,
  output logic           w_wr_en,
  output logic [WAW-1:0] w_wr_addr,
  input  logic           a_valid,
  output logic           a_ready,
  output logic           mac_en,
  output logic [WAW-1:0] mac_rd_addr,
  output logic           acc_clr,
  output logic           acc_last,
  input  logic           out_ready,
  output logic           out_tlast,
  output logic [FW-1:0]  fold_idx,
  input  logic           b_valid,
  output logic           b_ready,
  output logic           b_wr_en,
  output logic [2:0]     state_dbg
);

  // Reject configurations whose folds do not tile the channel counts.
  if (OC % PE != 0) begin : g_bad_oc
    $error("cnn_layer_sequencer: OC must be a multiple of PE");
  end
  if (IC % SIMD != 0) begin : g_bad_ic
    $error("cnn_layer_sequencer: IC must be a multiple of SIMD");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_W  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [WAW-1:0] W_LAST = WAW'(WFOLD - 1);
  localparam logic [PXW-1:0] P_LAST = PXW'(NPIX - 1);
  localparam logic [FW-1:0]  F_LAST = FW'(NF - 1);

`ifdef BIAS_LOAD_EN
  localparam state_t FOLD_ENTRY = S_LOAD_B;
`else
  localparam state_t FOLD_ENTRY = S_LOAD_W;
`endif

  state_t         state;
  logic [WAW-1:0] wcnt;
  logic [WAW-1:0] beat;
  logic [PXW-1:0] pix;
  logic [FW-1:0]  fold;

  // Stream handshakes and MAC strobes decoded from state and counters.
  assign ap_idle     = (state == S_IDLE);
  assign ap_done     = (state == S_DONE);
  assign w_ready     = (state == S_LOAD_W);
  assign w_wr_en     = w_valid && w_ready;
  assign w_wr_addr   = wcnt;
  assign a_ready     = (state == S_COMPUTE) && !((beat == W_LAST) && !out_ready);
  assign mac_en      = a_valid && a_ready;
  assign mac_rd_addr = beat;
  assign acc_clr     = mac_en && (beat == '0);
  assign acc_last    = mac_en && (beat == W_LAST);
  assign out_tlast   = acc_last && (pix == P_LAST) && (fold == F_LAST);
  assign fold_idx    = fold;
  assign state_dbg   = state;

`ifdef BIAS_LOAD_EN
  assign b_ready = (state == S_LOAD_B);
  assign b_wr_en = b_valid && b_ready;
`else
  logic b_valid_unused;
  assign b_valid_unused = b_valid;
  assign b_ready = 1'b0;
  assign b_wr_en = 1'b0;
`endif

  // Layer sequencing: fold entry, weight load, pixel/beat iteration, done.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
      beat  <= '0;
      pix   <= '0;
      fold  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            fold  <= '0;
            state <= FOLD_ENTRY;
          end
        end
`ifdef BIAS_LOAD_EN
        S_LOAD_B: begin
          if (b_wr_en) state <= S_LOAD_W;
        end
`endif
        S_LOAD_W: begin
          if (w_wr_en) begin
            if (wcnt == W_LAST) begin
              wcnt  <= '0;
              state <= S_COMPUTE;
            end else begin
              wcnt <= wcnt + WAW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (mac_en) begin
            if (beat == W_LAST) begin
              beat <= '0;
              if (pix == P_LAST) begin
                pix <= '0;
                if (fold == F_LAST) begin
                  state <= S_DONE;
                end else begin
                  fold  <= fold + FW'(1);
                  state <= FOLD_ENTRY;
                end
              end else begin
                pix <= pix + PXW'(1);
              end
            end else begin
              beat <= beat + WAW'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer with a small geometry (NF=2, WFOLD=2, NPIX=4).
// A transaction-count model (weights, biases and MAC beats accepted so far in
// the layer) predicts every output each cycle; directed scenarios pin the
// model with hand-counted totals. Inputs change 1 time unit after posedge,
// outputs are compared on negedge, the model advances on posedge.
module tb_cnn_layer_sequencer;

  localparam int PE = 2, SIMD = 2, IC = 4, OC = 4, KH = 1, KW = 1, OH = 2, OW = 2;
  localparam int NF = OC / PE;
  localparam int WFOLD = KH * KW * IC / SIMD;
  localparam int NPIX = OH * OW;
  localparam int PER_FOLD = WFOLD * NPIX;
  localparam int TOTAL = NF * PER_FOLD;
  localparam int WAW = ($clog2(WFOLD) > 1) ? $clog2(WFOLD) : 1;
  localparam int FW = $clog2(NF) + 1;
`ifdef BIAS_LOAD_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic ap_clk, ap_rst_n, ap_start, ap_idle, ap_done;
  logic w_valid, w_ready, w_wr_en;
  logic [WAW-1:0] w_wr_addr, mac_rd_addr;
  logic a_valid, a_ready, mac_en, acc_clr, acc_last, out_ready, out_tlast;
  logic [FW-1:0] fold_idx;
  logic b_valid, b_ready, b_wr_en;
  logic [2:0] state_dbg;

  cnn_layer_sequencer #(.PE(PE), .SIMD(SIMD), .IC(IC), .OC(OC), .KH(KH), .KW(KW), .OH(OH), .OW(OW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .w_valid(w_valid), .w_ready(w_ready), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .a_valid(a_valid), .a_ready(a_ready), .mac_en(mac_en), .mac_rd_addr(mac_rd_addr),
    .acc_clr(acc_clr), .acc_last(acc_last), .out_ready(out_ready), .out_tlast(out_tlast),
    .fold_idx(fold_idx), .b_valid(b_valid), .b_ready(b_ready), .b_wr_en(b_wr_en),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_run, m_dp;          // layer in progress / done pulse pending
  int m_nw, m_nb, m_nm;     // weights, biases, MAC beats accepted this layer
  int m_held;               // fold index shown when no layer is running
  bit h_w, h_b, h_m;        // predicted transfers for the coming edge

  // Observed event counters (from DUT outputs at compare time).
  int ev_w = 0, ev_b = 0, ev_mac = 0, ev_clr = 0, ev_last = 0, ev_tlast = 0, ev_tlast_at = 0, ev_done = 0;

  // Model advance on the active edge.
  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_run = 0; m_dp = 0; m_nw = 0; m_nb = 0; m_nm = 0; m_held = 0;
    end else if (m_dp) begin
      m_dp = 0;
    end else if (!m_run) begin
      if (ap_start) begin
        m_run = 1; m_nw = 0; m_nb = 0; m_nm = 0;
      end
    end else begin
      if (h_w) m_nw++;
      if (h_b) m_nb++;
      if (h_m) begin
        m_nm++;
        if (m_nm == TOTAL) begin
          m_run = 0; m_dp = 1; m_held = NF - 1;
        end
      end
    end
  end

  // Compare process: predict all outputs and check them every cycle.
  always @(negedge ap_clk) begin
    int fcur, bm;
    bit ld_b, ld_w, cmp, lastb;
    bit e_idle, e_done, e_wr, e_wwr, e_ar, e_mac, e_clr, e_last, e_tlast, e_br, e_bwr;
    int e_waddr, e_raddr, e_fold;
    fcur = 0; bm = 0; ld_b = 0; ld_w = 0; cmp = 0; lastb = 0;
    if (!ap_rst_n) begin
      e_idle = 1; e_fold = 0;
    end else begin
      e_idle = !m_run && !m_dp;
      if (m_run) begin
        fcur = m_nm / PER_FOLD;
        if (BIAS && m_nb < fcur + 1) ld_b = 1;
        else if (m_nw < (fcur + 1) * WFOLD) ld_w = 1;
        else cmp = 1;
      end
      bm = m_nm % WFOLD;
      lastb = (bm == WFOLD - 1);
      e_fold = m_run ? fcur : m_held;
    end
    e_done = ap_rst_n && m_dp;
    e_wr = ld_w;
    e_wwr = ld_w && w_valid;
    e_waddr = ld_w ? (m_nw % WFOLD) : 0;
    e_ar = cmp && !(lastb && !out_ready);
    e_mac = e_ar && a_valid;
    e_raddr = cmp ? bm : 0;
    e_clr = e_mac && (bm == 0);
    e_last = e_mac && lastb;
    e_tlast = e_last && (m_nm == TOTAL - 1);
    e_br = ld_b;
    e_bwr = ld_b && b_valid;
    h_w = e_wwr; h_b = e_bwr; h_m = e_mac;

    chk("ap_idle", ap_idle, e_idle);
    chk("ap_done", ap_done, e_done);
    chk("w_ready", w_ready, e_wr);
    chk("w_wr_en", w_wr_en, e_wwr);
    chk("w_wr_addr", w_wr_addr, e_waddr);
    chk("a_ready", a_ready, e_ar);
    chk("mac_en", mac_en, e_mac);
    chk("mac_rd_addr", mac_rd_addr, e_raddr);
    chk("acc_clr", acc_clr, e_clr);
    chk("acc_last", acc_last, e_last);
    chk("out_tlast", out_tlast, e_tlast);
    chk("fold_idx", fold_idx, e_fold);
    chk("b_ready", b_ready, e_br);
    chk("b_wr_en", b_wr_en, e_bwr);

    if (w_wr_en) ev_w++;
    if (b_wr_en) ev_b++;
    if (mac_en) ev_mac++;
    if (acc_clr) ev_clr++;
    if (acc_last) ev_last++;
    if (out_tlast) begin ev_tlast++; ev_tlast_at = ev_mac; end
    if (ap_done) ev_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ap_clk); #1;
  endtask

  task automatic set_all(input logic v, input logic o);
    w_valid = v; a_valid = v; b_valid = v; out_ready = o;
  endtask

  task automatic pulse_start();
    ap_start = 1; step(); ap_start = 0;
  endtask

  // mode 0: hold inputs, 1: randomize valids/out_ready, 2: toggle w_valid
  task automatic wait_done(input string name, input int mode);
    int base;
    bit seen;
    base = ev_done; seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      if (ev_done > base) seen = 1;
      else if (mode == 1) begin
        w_valid = 1'($urandom_range(0, 1)); a_valid = 1'($urandom_range(0, 1));
        b_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        w_valid = ~w_valid;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b_w, b_b, b_m, b_c, b_l, b_t, b_d;
    bit hit;
    ap_rst_n = 0; ap_start = 0; set_all(0, 0);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1;
    @(negedge ap_clk); #1;
    chk("rst_idle", ap_idle, 1);
    chk("rst_fold", fold_idx, 0);
    chk("rst_done", ap_done, 0);

    // 1: full-rate layer
    step();
    set_all(1, 1);
    b_w = ev_w; b_b = ev_b; b_m = ev_mac; b_c = ev_clr; b_l = ev_last; b_t = ev_tlast; b_d = ev_done;
    pulse_start();
    wait_done("t1", 0);
    step();
    chk("t1_w_writes", ev_w - b_w, 4);
    chk("t1_b_writes", ev_b - b_b, BIAS ? 2 : 0);
    chk("t1_mac_beats", ev_mac - b_m, 16);
    chk("t1_acc_clr", ev_clr - b_c, 8);
    chk("t1_acc_last", ev_last - b_l, 8);
    chk("t1_tlast", ev_tlast - b_t, 1);
    chk("t1_tlast_beat", ev_tlast_at - b_m, 16);
    chk("t1_done_pulses", ev_done - b_d, 1);
    chk("t1_idle_after", ap_idle, 1);
    chk("t1_fold_after", fold_idx, NF - 1);

    // 2: output backpressure on a pixel's last beat
    set_all(1, 0);
    b_m = ev_mac; b_l = ev_last; b_d = ev_done;
    pulse_start();
    repeat (12) step();
    chk("t2_beats_before_release", ev_mac - b_m, 1);
    chk("t2_last_held", ev_last - b_l, 0);
    chk("t2_rd_addr_held", mac_rd_addr, 1);
    out_ready = 1;
    step(); step();
    chk("t2_last_after_release", ev_last - b_l, 1);
    wait_done("t2", 0);
    chk("t2_done_pulses", ev_done - b_d, 1);

    // 3: weight stream valid every other cycle
    step();
    set_all(1, 1); w_valid = 0;
    b_w = ev_w; b_m = ev_mac;
    pulse_start();
    wait_done("t3", 2);
    chk("t3_w_writes", ev_w - b_w, 4);
    chk("t3_mac_beats", ev_mac - b_m, 16);

    // 4: reset in the middle of COMPUTE at pix=2
    step();
    set_all(1, 1);
    b_m = ev_mac; b_d = ev_done;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (ev_mac - b_m >= 2 * WFOLD) hit = 1;
    end
    chk("t4_reach_pix2", 32'(hit), 1);
    ap_rst_n = 0;
    @(negedge ap_clk); #1;
    chk("t4_rst_idle", ap_idle, 1);
    chk("t4_rst_mac_en", mac_en, 0);
    chk("t4_rst_fold", fold_idx, 0);
    step(); step();
    ap_rst_n = 1;
    step(); step();
    chk("t4_no_done", ev_done - b_d, 0);
    b_m = ev_mac; b_t = ev_tlast;
    pulse_start();
    wait_done("t4", 0);
    chk("t4_replay_beats", ev_mac - b_m, 16);
    chk("t4_replay_tlast_beat", ev_tlast_at - b_m, 16);
    chk("t4_replay_tlast", ev_tlast - b_t, 1);

    // 5: ap_start held high through two layers
    step();
    b_d = ev_done; b_m = ev_mac;
    ap_start = 1;
    wait_done("t5a", 0);
    wait_done("t5b", 0);
    ap_start = 0;
    chk("t5_done_pulses", ev_done - b_d, 2);
    chk("t5_mac_beats", ev_mac - b_m, 32);
    step(); step();

    // 6: randomized traffic, random ap_start level, rare resets
    b_d = ev_done;
    for (int i = 0; i < 4000; i++) begin
      step();
      ap_start = ($urandom_range(0, 3) != 0);
      w_valid = 1'($urandom_range(0, 1)); a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      ap_rst_n = ($urandom_range(0, 999) != 0);
    end
    ap_rst_n = 1; ap_start = 0;
    chk("t6_layers_completed", 32'(ev_done - b_d > 0), 1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
